// File: rtl/cmp_sched_pkg.sv
// cmp_sched_pkg: op codes and op width shared by the compare scheduler.
package cmp_sched_pkg;
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {OP_EQ, OP_NEQ, OP_LT, OP_GE} op_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at ptr, wrapping past N-1 to 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);
    int s;
    logic [PW-1:0] idx;
    always_comb begin
        gnt = '0;
        s = 0;
        idx = '0;
        // Scan farthest-first so the nearest requester at or after ptr wins last.
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            s = s >= N ? s - N : s;
            idx = PW'(s);
            if (en && req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one compare unit across NREQ requesters.
// Define CMP_SCHED_STATS_EN to enable the completed-response counter on stat_count.
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W = 8,
    localparam int IW = $clog2(NREQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*W-1:0]  req_a,
    input  logic [NREQ*W-1:0]  req_b,
    input  logic [NREQ*OP_W-1:0] req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic               rsp_y,
    output logic [31:0]        stat_count
);
    logic [IW-1:0] ptr, gid;
    logic [W-1:0] a, b;
    op_e op;
    logic y, free;
    assign free = !rsp_valid || rsp_ready;
    // Gating with reset keeps req_ready low for the whole reset assertion.
    rr_arbiter #(.N(NREQ)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .en(free && reset),
        .gnt(req_ready)
    );
    always_comb begin
        gid = '0;
        for (int i = 0; i < NREQ; i++) gid = req_ready[i] ? IW'(i) : gid;
    end
    assign a = req_a[gid*W +: W];
    assign b = req_b[gid*W +: W];
    assign op = op_e'(req_op[gid*OP_W +: OP_W]);
    assign y = op == OP_EQ ? a == b : op == OP_NEQ ? a != b : op == OP_LT ? a < b : a >= b;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_y <= 1'b0;
            ptr <= '0;
        end else if (|req_ready) begin
            rsp_valid <= 1'b1;
            rsp_id <= gid;
            rsp_y <= y;
            ptr <= gid == IW'(NREQ - 1) ? '0 : gid + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
`ifdef CMP_SCHED_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stat_count <= '0;
        else if (rsp_valid && rsp_ready) stat_count <= stat_count + 32'd1;
    end
`else
    assign stat_count = '0;
`endif
endmodule

// File: doc/cmp_sched.md
CMP_SCHED -- requirements
Module: cmp_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter W, default 8, operand width in bits.
REQ-003 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester request valid.
REQ-006 SHALL have port req_ready  out  NREQ  per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a  in  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-008 SHALL have port req_b  in  NREQ*W  packed operand B, same packing.
REQ-009 SHALL have port req_op  in  NREQ*2  packed op code, 2 bits per requester.
REQ-010 SHALL have port rsp_valid  out  1  response valid.
REQ-011 SHALL have port rsp_ready  in  1  response consumer ready.
REQ-012 SHALL have port rsp_id  out  clog2(NREQ)  index of the requester that owns the response.
REQ-013 SHALL have port rsp_y  out  1  comparison result.
REQ-014 SHALL have port stat_count  out  32  count of completed responses.

Function
REQ-015 SHALL share one unsigned W-bit compare unit: op 0 EQ (a==b), 1 NEQ (a!=b), 2 LT (a<b), 3 GE (a>=b).
REQ-016 SHALL define slot free = !rsp_valid || rsp_ready.
REQ-017 SHALL grant only when the slot is free, and SHALL grant at most one requester per cycle.
REQ-018 SHALL drive req_ready combinationally as the grant vector, and SHALL keep it all-zero when no request is granted.
REQ-019 SHALL arbitrate round-robin: grant the lowest index >= ptr with req_valid set, wrapping past NREQ-1 to 0.
REQ-020 SHALL set ptr to (granted index + 1) mod NREQ on each transfer, and SHALL leave ptr unchanged otherwise.
REQ-021 SHALL treat a transfer as req_valid[i] && req_ready[i] at a rising edge; requesters hold valid and operands until that transfer.
REQ-022 SHALL have a latency of 1: a transfer at edge N raises rsp_valid with rsp_id/rsp_y after edge N and before edge N+1.
REQ-023 SHALL hold rsp_valid, rsp_id and rsp_y stable while rsp_valid && !rsp_ready.
REQ-024 SHALL, on a simultaneous response consume and new transfer, load the new result in the same edge (1 result/cycle throughput).
REQ-025 SHALL clear rsp_valid after a consume edge with no new transfer.
REQ-026 SHALL let the arbitration and compare logic ignore req_a/req_b/req_op of non-granted requesters.

Reset
REQ-027 SHALL, while reset is low, asynchronously force rsp_valid=0, rsp_id=0, rsp_y=0, ptr=0 and stat_count=0.
REQ-028 SHALL hold req_ready all-zero while reset is low.
REQ-029 SHALL discard a pending response on reset assertion mid-operation; no response SHALL be replayed after release.
REQ-030 SHALL start arbitration from requester 0 on the first edge after reset release.

Configuration
REQ-031 SHALL, with CMP_SCHED_STATS_EN defined, increment stat_count on each rsp_valid && rsp_ready edge, wrapping modulo 2^32.
REQ-032 SHALL, with CMP_SCHED_STATS_EN undefined, tie stat_count to 0, keep the port present and instantiate no counter.

Structure
REQ-033 SHALL place the op-code enum (OP_EQ, OP_NEQ, OP_LT, OP_GE) and the op width constant in package cmp_sched_pkg.
REQ-034 SHALL implement the round-robin grant logic as sub-module rr_arbiter (inputs: request vector, ptr, enable; output: one-hot grant); the compare unit and output register SHALL stay in cmp_sched.

Verification
REQ-035 SHALL cover: req0 a=3, b=3, op NEQ, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_id=0, rsp_y=0; with op EQ -> rsp_y=1.
REQ-036 SHALL cover: all 4 req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles and one response per cycle with matching rsp_id.
REQ-037 SHALL cover: rsp_ready=0 with a response pending -> req_ready=0000 and rsp_* stable for 5 cycles; rsp_ready=1 -> the next grant occurs in that cycle.
REQ-038 SHALL cover: ptr=3 with only req2 valid, a=5, b=9, op LT -> wrap-around grant of requester 2, rsp_id=2, rsp_y=1.
REQ-039 SHALL cover: reset pulled low mid-stream with rsp_valid=1 -> rsp_valid drops without a clock edge; after release with all requests valid, first grant is requester 0.
REQ-040 SHALL cover: 10 consumed responses -> stat_count=10 with CMP_SCHED_STATS_EN defined, and stat_count=0 without it.
